// File: rtl/sprite_compositor.sv
// sprite_compositor: composites NUM_SPR double-buffered sprites plus a
// game-over overlay into one palette index per pixel (3-cycle pipeline).
// Optional macro OVERLAY_BLINK_EN: blinks the overlay with a frame counter.
module sprite_compositor #(
   parameter int NUM_SPR    = 8,
   parameter int COORD_W    = 10,
   parameter int IDX_W      = 6,
   parameter int SPR_W      = 16,
   parameter int SPR_H      = 16,
   parameter int OVL_X      = 112,
   parameter int OVL_Y      = 120,
   parameter int OVL_W      = 32,
   parameter int OVL_H      = 16,
   parameter int BLINK_LOG2 = 5
) (
   input  logic                                Clk,
   input  logic                                Reset,
   input  logic                                pix_en,
   input  logic [COORD_W-1:0]                  DrawX,
   input  logic [COORD_W-1:0]                  DrawY,
   input  logic                                frame_start,
   input  logic                                attr_we,
   input  logic [$clog2(NUM_SPR)-1:0]          attr_sel,
   input  logic [COORD_W-1:0]                  attr_x,
   input  logic [COORD_W-1:0]                  attr_y,
   input  logic [1:0]                          attr_frame,
   input  logic                                attr_en,
   input  logic                                game_over,
   output logic [NUM_SPR*$clog2(SPR_W)-1:0]    spr_lx,
   output logic [NUM_SPR*$clog2(SPR_H)-1:0]    spr_ly,
   output logic [NUM_SPR*2-1:0]                spr_frame,
   output logic [$clog2(OVL_W)-1:0]            ovl_lx,
   output logic [$clog2(OVL_H)-1:0]            ovl_ly,
   input  logic [NUM_SPR*IDX_W-1:0]            spr_idx,
   input  logic [IDX_W-1:0]                    ovl_idx,
   output logic [IDX_W-1:0]                    pix_idx,
   output logic                                pix_valid
);

   localparam int SEL_W = $clog2(NUM_SPR);
   localparam int LX_W  = $clog2(SPR_W);
   localparam int LY_W  = $clog2(SPR_H);
   localparam int OLX_W = $clog2(OVL_W);
   localparam int OLY_W = $clog2(OVL_H);
   localparam int CW1   = COORD_W + 1;

   logic [NUM_SPR-1:0] hit1_vec;
   logic [NUM_SPR-1:0] hit2_reg;
   logic               valid1_reg, valid2_reg;
   logic               go1_reg, go2_reg;
   logic               ovl_hit1_reg, ovl_hit2_reg;
   logic               ovl_hit;
   logic               ovl_show;
   logic [OLX_W-1:0]   ovl_lx_reg;
   logic [OLY_W-1:0]   ovl_ly_reg;
   logic [IDX_W-1:0]   pix_idx_reg, pix_idx_next;
   logic               pix_valid_reg;

   // Per-channel attribute buffers and stage-1 hit test
   for (genvar gi = 0; gi < NUM_SPR; gi++) begin : g_ch
      logic [COORD_W-1:0] sh_x_reg, sh_y_reg, act_x_reg, act_y_reg;
      logic [1:0]         sh_fr_reg, act_fr_reg;
      logic               sh_en_reg, act_en_reg;
      logic               hit;
      logic [LX_W-1:0]    lx_reg;
      logic [LY_W-1:0]    ly_reg;
      logic [1:0]         fr_reg;
      logic               hit_reg;

      // Shadow takes writes; active copies the old shadow at frame start
      always_ff @(posedge Clk) begin
         if (Reset) begin
            sh_x_reg   <= '0;
            sh_y_reg   <= '0;
            sh_fr_reg  <= '0;
            sh_en_reg  <= 1'b0;
            act_x_reg  <= '0;
            act_y_reg  <= '0;
            act_fr_reg <= '0;
            act_en_reg <= 1'b0;
         end else begin
            if (attr_we && attr_sel == SEL_W'(gi)) begin
               sh_x_reg  <= attr_x;
               sh_y_reg  <= attr_y;
               sh_fr_reg <= attr_frame;
               sh_en_reg <= attr_en;
            end
            if (frame_start) begin
               act_x_reg  <= sh_x_reg;
               act_y_reg  <= sh_y_reg;
               act_fr_reg <= sh_fr_reg;
               act_en_reg <= sh_en_reg;
            end
         end
      end

      // Bounds compared one bit wider so a sprite at the edge clips rather than wraps
      assign hit = pix_en && act_en_reg
                && ({1'b0, DrawX} >= {1'b0, act_x_reg})
                && ({1'b0, DrawX} <  {1'b0, act_x_reg} + CW1'(SPR_W))
                && ({1'b0, DrawY} >= {1'b0, act_y_reg})
                && ({1'b0, DrawY} <  {1'b0, act_y_reg} + CW1'(SPR_H));

      // Stage 1: register hit and ROM address (zero address on a miss)
      always_ff @(posedge Clk) begin
         if (Reset) begin
            hit_reg <= 1'b0;
            lx_reg  <= '0;
            ly_reg  <= '0;
            fr_reg  <= '0;
         end else begin
            hit_reg <= hit;
            lx_reg  <= hit ? LX_W'(DrawX - act_x_reg) : '0;
            ly_reg  <= hit ? LY_W'(DrawY - act_y_reg) : '0;
            fr_reg  <= act_fr_reg;
         end
      end

      assign hit1_vec[gi]                   = hit_reg;
      assign spr_lx[gi*LX_W +: LX_W]        = lx_reg;
      assign spr_ly[gi*LY_W +: LY_W]        = ly_reg;
      assign spr_frame[gi*2 +: 2]           = fr_reg;
   end

`ifdef OVERLAY_BLINK_EN
   logic [BLINK_LOG2:0] blink_cnt_reg;

   // Frames spent in game-over; MSB selects the blank half of the blink
   always_ff @(posedge Clk) begin
      if (Reset || !game_over) begin
         blink_cnt_reg <= '0;
      end else if (frame_start) begin
         blink_cnt_reg <= blink_cnt_reg + 1'b1;
      end
   end

   assign ovl_show = ~blink_cnt_reg[BLINK_LOG2];
`else
   assign ovl_show = 1'b1;
`endif

   assign ovl_hit = pix_en && ovl_show
                 && ({1'b0, DrawX} >= CW1'(OVL_X))
                 && ({1'b0, DrawX} <  CW1'(OVL_X + OVL_W))
                 && ({1'b0, DrawY} >= CW1'(OVL_Y))
                 && ({1'b0, DrawY} <  CW1'(OVL_Y + OVL_H));

   // Stages 1 and 2: overlay address, pipe control bits delayed to meet ROM data
   always_ff @(posedge Clk) begin
      if (Reset) begin
         valid1_reg   <= 1'b0;
         go1_reg      <= 1'b0;
         ovl_hit1_reg <= 1'b0;
         ovl_lx_reg   <= '0;
         ovl_ly_reg   <= '0;
         valid2_reg   <= 1'b0;
         go2_reg      <= 1'b0;
         ovl_hit2_reg <= 1'b0;
         hit2_reg     <= '0;
      end else begin
         valid1_reg   <= pix_en;
         go1_reg      <= game_over;
         ovl_hit1_reg <= ovl_hit;
         ovl_lx_reg   <= ovl_hit ? OLX_W'(DrawX - COORD_W'(OVL_X)) : '0;
         ovl_ly_reg   <= ovl_hit ? OLY_W'(DrawY - COORD_W'(OVL_Y)) : '0;
         valid2_reg   <= valid1_reg;
         go2_reg      <= go1_reg;
         ovl_hit2_reg <= ovl_hit1_reg;
         hit2_reg     <= hit1_vec;
      end
   end

   // Priority pick: lowest channel with a hit and an opaque index wins
   always_comb begin
      pix_idx_next = '0;
      if (valid2_reg) begin
         if (go2_reg) begin
            if (ovl_hit2_reg) begin
               pix_idx_next = ovl_idx;
            end
         end else begin
            for (int i = NUM_SPR - 1; i >= 0; i--) begin
               if (hit2_reg[i] && spr_idx[i*IDX_W +: IDX_W] != '0) begin
                  pix_idx_next = spr_idx[i*IDX_W +: IDX_W];
               end
            end
         end
      end
   end

   // Stage 3: registered output
   always_ff @(posedge Clk) begin
      if (Reset) begin
         pix_idx_reg   <= '0;
         pix_valid_reg <= 1'b0;
      end else begin
         pix_idx_reg   <= pix_idx_next;
         pix_valid_reg <= valid2_reg;
      end
   end

   assign ovl_lx    = ovl_lx_reg;
   assign ovl_ly    = ovl_ly_reg;
   assign pix_idx   = pix_idx_reg;
   assign pix_valid = pix_valid_reg;

endmodule

// File: tb/tb_sprite_compositor.sv
// tb_sprite_compositor: directed + randomized stimulus against a
// geometric reference model of the compositor, with external ROM models.
module tb_sprite_compositor;

   localparam int NUM_SPR    = 8;
   localparam int COORD_W    = 10;
   localparam int IDX_W      = 6;
   localparam int SPR_W      = 16;
   localparam int SPR_H      = 16;
   localparam int OVL_X      = 112;
   localparam int OVL_Y      = 120;
   localparam int OVL_W      = 32;
   localparam int OVL_H      = 16;
   localparam int BLINK_LOG2 = 5;
   localparam int SEL_W      = 3;
   localparam int LX_W       = 4;
   localparam int LY_W       = 4;
   localparam int EMAX       = 12000;

   logic                       Clk = 1'b0;
   logic                       Reset = 1'b1;
   logic                       pix_en = 1'b0;
   logic [COORD_W-1:0]         DrawX = '0;
   logic [COORD_W-1:0]         DrawY = '0;
   logic                       frame_start = 1'b0;
   logic                       attr_we = 1'b0;
   logic [SEL_W-1:0]           attr_sel = '0;
   logic [COORD_W-1:0]         attr_x = '0;
   logic [COORD_W-1:0]         attr_y = '0;
   logic [1:0]                 attr_frame = '0;
   logic                       attr_en = 1'b0;
   logic                       game_over = 1'b0;
   logic [NUM_SPR*LX_W-1:0]    spr_lx;
   logic [NUM_SPR*LY_W-1:0]    spr_ly;
   logic [NUM_SPR*2-1:0]       spr_frame;
   logic [4:0]                 ovl_lx;
   logic [3:0]                 ovl_ly;
   logic [NUM_SPR*IDX_W-1:0]   spr_idx = '0;
   logic [IDX_W-1:0]           ovl_idx = '0;
   logic [IDX_W-1:0]           pix_idx;
   logic                       pix_valid;

   sprite_compositor #(
      .NUM_SPR(NUM_SPR), .COORD_W(COORD_W), .IDX_W(IDX_W), .SPR_W(SPR_W), .SPR_H(SPR_H),
      .OVL_X(OVL_X), .OVL_Y(OVL_Y), .OVL_W(OVL_W), .OVL_H(OVL_H), .BLINK_LOG2(BLINK_LOG2)
   ) dut (
      .Clk(Clk), .Reset(Reset), .pix_en(pix_en), .DrawX(DrawX), .DrawY(DrawY),
      .frame_start(frame_start), .attr_we(attr_we), .attr_sel(attr_sel),
      .attr_x(attr_x), .attr_y(attr_y), .attr_frame(attr_frame), .attr_en(attr_en),
      .game_over(game_over), .spr_lx(spr_lx), .spr_ly(spr_ly), .spr_frame(spr_frame),
      .ovl_lx(ovl_lx), .ovl_ly(ovl_ly), .spr_idx(spr_idx), .ovl_idx(ovl_idx),
      .pix_idx(pix_idx), .pix_valid(pix_valid)
   );

   always #5 Clk = ~Clk;

   // External ROM contents
   logic [IDX_W-1:0] spr_rom [NUM_SPR][4][SPR_H][SPR_W];
   logic [IDX_W-1:0] ovl_rom [OVL_H][OVL_W];

   // Synchronous ROMs: data one cycle after address
   always @(posedge Clk) begin
      for (int c = 0; c < NUM_SPR; c++)
         spr_idx[c*IDX_W +: IDX_W] <= spr_rom[c][spr_frame[c*2 +: 2]][spr_ly[c*LY_W +: LY_W]][spr_lx[c*LX_W +: LX_W]];
      ovl_idx <= ovl_rom[ovl_ly][ovl_lx];
   end

   int edge_cnt = 0;
   always @(posedge Clk) edge_cnt <= edge_cnt + 1;

   // Reference model state
   int m_sh_x [NUM_SPR], m_sh_y [NUM_SPR], m_sh_fr [NUM_SPR], m_sh_en [NUM_SPR];
   int m_act_x[NUM_SPR], m_act_y[NUM_SPR], m_act_fr[NUM_SPR], m_act_en[NUM_SPR];
   int m_blink = 0;

   // Expected values indexed by the clock edge after which they are visible
   bit [IDX_W-1:0]          e_idx [EMAX];
   bit                      e_val [EMAX];
   bit [NUM_SPR*LX_W-1:0]   e_lx  [EMAX];
   bit [NUM_SPR*LY_W-1:0]   e_ly  [EMAX];
   bit [NUM_SPR*2-1:0]      e_fr  [EMAX];
   bit [4:0]                e_olx [EMAX];
   bit [3:0]                e_oly [EMAX];

   int n_checks = 0;
   int n_fail   = 0;

   // Every-cycle comparison of DUT outputs against the model
   always @(negedge Clk) begin
      int e;
      e = edge_cnt;
      n_checks++;
      if (pix_valid !== e_val[e] || pix_idx !== e_idx[e]) begin
         n_fail++;
         $display("FAIL pix edge=%0d: got valid=%0b idx=%0d, expected valid=%0b idx=%0d",
                  e, pix_valid, pix_idx, e_val[e], e_idx[e]);
      end
      n_checks++;
      if (spr_lx !== e_lx[e] || spr_ly !== e_ly[e] || spr_frame !== e_fr[e] ||
          ovl_lx !== e_olx[e] || ovl_ly !== e_oly[e]) begin
         n_fail++;
         $display("FAIL addr edge=%0d: got lx=%h ly=%h fr=%h olx=%0d oly=%0d, expected lx=%h ly=%h fr=%h olx=%0d oly=%0d",
                  e, spr_lx, spr_ly, spr_frame, ovl_lx, ovl_ly,
                  e_lx[e], e_ly[e], e_fr[e], e_olx[e], e_oly[e]);
      end
   end

   task automatic chk(input string name, input int got, input int expv);
      n_checks++;
      if (got != expv) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, got, expv);
      end
   endtask

   // Predict results for the current inputs, update the model, advance one clock
   task automatic step();
      int k, px, py, lx, ly, fr, olx, oly, best;
      bit found, h, show, ohit;
      bit [NUM_SPR*LX_W-1:0] lxv;
      bit [NUM_SPR*LY_W-1:0] lyv;
      bit [NUM_SPR*2-1:0]    frv;
      k = edge_cnt + 1;
      if (k + 2 >= EMAX) begin
         $display("FAIL budget: edge %0d exceeds table size %0d", k, EMAX);
         $fatal(1);
      end
      if (Reset) begin
         for (int j = 0; j < 3; j++) begin
            e_val[k+j] = 1'b0;
            e_idx[k+j] = '0;
         end
         e_lx[k] = '0; e_ly[k] = '0; e_fr[k] = '0; e_olx[k] = '0; e_oly[k] = '0;
         for (int c = 0; c < NUM_SPR; c++) begin
            m_sh_x[c] = 0; m_sh_y[c] = 0; m_sh_fr[c] = 0; m_sh_en[c] = 0;
            m_act_x[c] = 0; m_act_y[c] = 0; m_act_fr[c] = 0; m_act_en[c] = 0;
         end
         m_blink = 0;
      end else begin
         px = int'(DrawX); py = int'(DrawY);
         lxv = '0; lyv = '0; frv = '0; found = 1'b0; best = 0;
         for (int c = 0; c < NUM_SPR; c++) begin
            h = pix_en && m_act_en[c] != 0 && px >= m_act_x[c] && px < m_act_x[c] + SPR_W
                && py >= m_act_y[c] && py < m_act_y[c] + SPR_H;
            frv[c*2 +: 2] = 2'(m_act_fr[c]);
            if (h) begin
               lx = px - m_act_x[c]; ly = py - m_act_y[c]; fr = m_act_fr[c];
               lxv[c*LX_W +: LX_W] = LX_W'(lx);
               lyv[c*LY_W +: LY_W] = LY_W'(ly);
               if (!found && spr_rom[c][fr][ly][lx] != 0) begin
                  found = 1'b1;
                  best = int'(spr_rom[c][fr][ly][lx]);
               end
            end
         end
`ifdef OVERLAY_BLINK_EN
         show = m_blink < (1 << BLINK_LOG2);
`else
         show = 1'b1;
`endif
         ohit = pix_en && show && px >= OVL_X && px < OVL_X + OVL_W && py >= OVL_Y && py < OVL_Y + OVL_H;
         olx = ohit ? px - OVL_X : 0;
         oly = ohit ? py - OVL_Y : 0;
         e_lx[k] = lxv; e_ly[k] = lyv; e_fr[k] = frv;
         e_olx[k] = 5'(olx); e_oly[k] = 4'(oly);
         e_val[k+2] = pix_en;
         if (!pix_en)        e_idx[k+2] = '0;
         else if (game_over) e_idx[k+2] = ohit ? ovl_rom[oly][olx] : '0;
         else                e_idx[k+2] = IDX_W'(best);
`ifdef OVERLAY_BLINK_EN
         if (!game_over)       m_blink = 0;
         else if (frame_start) m_blink = (m_blink + 1) % (1 << (BLINK_LOG2 + 1));
`endif
         if (frame_start) begin
            for (int c = 0; c < NUM_SPR; c++) begin
               m_act_x[c] = m_sh_x[c]; m_act_y[c] = m_sh_y[c];
               m_act_fr[c] = m_sh_fr[c]; m_act_en[c] = m_sh_en[c];
            end
         end
         if (attr_we) begin
            m_sh_x[attr_sel] = int'(attr_x); m_sh_y[attr_sel] = int'(attr_y);
            m_sh_fr[attr_sel] = int'(attr_frame); m_sh_en[attr_sel] = int'(attr_en);
         end
      end
      @(posedge Clk);
      #1;
      attr_we = 1'b0;
      frame_start = 1'b0;
   endtask

   task automatic write_attr(input int sel, input int x, input int y, input int fr, input int en);
      attr_we = 1'b1; attr_sel = SEL_W'(sel); attr_x = COORD_W'(x); attr_y = COORD_W'(y);
      attr_frame = 2'(fr); attr_en = en[0]; pix_en = 1'b0;
      step();
   endtask

   task automatic commit();
      frame_start = 1'b1; pix_en = 1'b0;
      step();
   endtask

   task automatic probe(input int x, input int y);
      DrawX = COORD_W'(x); DrawY = COORD_W'(y); pix_en = 1'b1;
      step();
   endtask

   task automatic drain2();
      pix_en = 1'b0;
      step();
      step();
   endtask

   task automatic fill_roms();
      for (int c = 0; c < NUM_SPR; c++)
         for (int f = 0; f < 4; f++)
            for (int y = 0; y < SPR_H; y++)
               for (int x = 0; x < SPR_W; x++)
                  spr_rom[c][f][y][x] = ($urandom_range(0, 99) < 40) ? '0 : IDX_W'($urandom_range(1, 63));
      for (int y = 0; y < OVL_H; y++)
         for (int x = 0; x < OVL_W; x++)
            ovl_rom[y][x] = ($urandom_range(0, 99) < 30) ? '0 : IDX_W'($urandom_range(1, 63));
   endtask

   initial begin
      int x, y;
      fill_roms();
      Reset = 1'b1;
      step(); step(); step();
      Reset = 1'b0;
      chk("reset pix_valid", int'(pix_valid), 0);
      chk("reset pix_idx", int'(pix_idx), 0);
      chk("reset spr_lx", int'(spr_lx), 0);

      // Empty scan: pix_valid tracks pix_en, index stays 0
      for (int i = 0; i < 640; i++) begin
         DrawX = COORD_W'(i); DrawY = '0; pix_en = (i % 7 != 3);
         step();
      end
      drain2();

      // Shadow write alone is invisible until commit
      spr_rom[0][1][3][5] = 6'd7;
      write_attr(0, 100, 50, 1, 1);
      probe(105, 53);
      chk("pre-commit lx ch0", int'(spr_lx[3:0]), 0);
      drain2();
      chk("pre-commit pix", int'(pix_idx), 0);
      commit();
      probe(105, 53);
      chk("lx ch0", int'(spr_lx[3:0]), 5);
      chk("ly ch0", int'(spr_ly[3:0]), 3);
      chk("frame ch0", int'(spr_frame[1:0]), 1);
      drain2();
      chk("pix ch0", int'(pix_idx), 7);
      chk("valid ch0", int'(pix_valid), 1);

      // Overlap: transparent ch0 falls through to ch2
      write_attr(0, 200, 80, 0, 1);
      write_attr(2, 200, 80, 0, 1);
      commit();
      spr_rom[0][0][0][0] = 6'd0;
      spr_rom[2][0][0][0] = 6'd12;
      probe(200, 80);
      drain2();
      chk("overlap transparent", int'(pix_idx), 12);
      spr_rom[0][0][0][0] = 6'd4;
      probe(200, 80);
      drain2();
      chk("overlap priority", int'(pix_idx), 4);

      // Right-edge sprite clips instead of wrapping
      write_attr(3, 1016, 0, 0, 1);
      commit();
      spr_rom[3][0][0][4] = 6'd21;
      spr_rom[3][0][0][3] = 6'd22;
      probe(1020, 0);
      chk("edge lx ch3", int'(spr_lx[15:12]), 4);
      drain2();
      chk("edge pix", int'(pix_idx), 21);
      probe(3, 0);
      chk("nowrap lx ch3", int'(spr_lx[15:12]), 0);
      drain2();
      chk("nowrap pix", int'(pix_idx), 0);

      // Write coinciding with commit lands in shadow only
      write_attr(1, 20, 0, 0, 1);
      commit();
      attr_we = 1'b1; attr_sel = 3'd1; attr_x = 10'd300; attr_y = '0; attr_frame = '0; attr_en = 1'b1;
      frame_start = 1'b1; pix_en = 1'b0;
      step();
      probe(25, 0);
      chk("same-cycle old x", int'(spr_lx[7:4]), 5);
      commit();
      probe(25, 0);
      chk("after commit old x", int'(spr_lx[7:4]), 0);
      probe(305, 0);
      chk("after commit new x", int'(spr_lx[7:4]), 5);
      drain2();

      // Game-over overlay suppresses sprites
      for (int yy = 0; yy < OVL_H; yy++)
         for (int xx = 0; xx < OVL_W; xx++)
            ovl_rom[yy][xx] = 6'd9;
      for (int yy = 0; yy < SPR_H; yy++)
         for (int xx = 0; xx < SPR_W; xx++)
            spr_rom[4][0][yy][xx] = 6'd33;
      write_attr(4, 106, 115, 0, 1);
      commit();
      game_over = 1'b1;
      for (int i = 100; i <= 150; i++) begin
         probe(i, 120);
         if (i >= 102 && (i == 102 || i == 111 || i == 112 || i == 143 || i == 144 || i == 130))
            chk($sformatf("overlay x=%0d", i - 2), int'(pix_idx), (i - 2 >= 112 && i - 2 <= 143) ? 9 : 0);
      end
      drain2();
`ifdef OVERLAY_BLINK_EN
      repeat (32) commit();
      probe(120, 120);
      drain2();
      chk("blink hidden", int'(pix_idx), 0);
      repeat (32) commit();
      probe(120, 120);
      drain2();
      chk("blink shown", int'(pix_idx), 9);
`endif
      game_over = 1'b0;
      pix_en = 1'b0;
      step();

      // Randomized traffic with occasional commits, mode changes and resets
      fill_roms();
      for (int i = 0; i < 3000; i++) begin
         Reset = ($urandom_range(0, 499) == 0);
         if ($urandom_range(0, 3) == 0) begin
            attr_we = 1'b1;
            attr_sel = SEL_W'($urandom_range(0, NUM_SPR - 1));
            attr_x = COORD_W'(($urandom_range(0, 3) == 0) ? $urandom_range(0, 1023) : $urandom_range(0, 90));
            attr_y = COORD_W'(($urandom_range(0, 3) == 0) ? $urandom_range(0, 1023) : $urandom_range(0, 90));
            attr_frame = 2'($urandom_range(0, 3));
            attr_en = ($urandom_range(0, 4) != 0);
         end
         frame_start = ($urandom_range(0, 29) == 0);
         if ($urandom_range(0, 199) == 0) game_over = ~game_over;
         pix_en = ($urandom_range(0, 99) < 85);
         case ($urandom_range(0, 9))
            0:       begin x = $urandom_range(0, 1023); y = $urandom_range(0, 1023); end
            1:       begin x = $urandom_range(100, 150); y = $urandom_range(110, 140); end
            default: begin x = $urandom_range(0, 110); y = $urandom_range(0, 110); end
         endcase
         DrawX = COORD_W'(x); DrawY = COORD_W'(y);
         step();
      end
      Reset = 1'b0;
      pix_en = 1'b0;
      repeat (4) step();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
